alu_wb_arbiter: RTL
===================

// Module: alu_wb_arbiter
// PURPOSE
//  Round-robin Wishbone arbiter directly upstream of alu_top: lets NM masters (voice/filter engines) share the one ALU.
//  Holds one registered grant per bus cycle and muxes the granted master's op/operands onto the ALU slave port.
//  Routes ack/stall/results back to that master only and tracks outstanding pipelined requests.
//  Releases the ALU only once it is idle.
// PARAMETERS
//  NM      4  number of masters (2..8)
//  OUT_W   2  outstanding-request counter width; limit = 2**OUT_W-1 (3, covers 3-cycle DSP ack latency)
// PORTS
//  clk        in   1       clock
//  reset      in   1       reset, asynchronous, active-high
//  m_cyc      in   NM      per-master Wishbone cycle
//  m_stb      in   NM      per-master strobe
//  m_op       in   NM*9    per-master alu_op, master i at [i*9+:9]
//  m_al/m_ar  in   NM*18   per-master A operands, [i*18+:18]
//  m_bl/m_br  in   NM*18   per-master B operands
//  m_cl/m_cr  in   NM*48   per-master C operands, [i*48+:48]
//  m_ack      out  NM      ack, granted master only
//  m_stall    out  NM      stall; 1 for every non-granted master
//  m_pl/m_pr  out  48      result broadcast; valid only with m_ack[i]
//  m_gnt      out  NM      one-hot registered grant, visible for debug
//  alu_cycle/alu_strobe  out 1   to alu_top
//  alu_op out 9; alu_al,alu_bl,alu_ar,alu_br out 18; alu_cl,alu_cr out 48
//  alu_ack/alu_stall     in  1   from alu_top
//  alu_pl/alu_pr         in  48  from alu_top
// BEHAVIOUR
//  Reset: state=IDLE, m_gnt=0, ptr=0, outst=0.
//   All outputs 0, except m_stall = all-ones.
//  FSM: IDLE / OWN / DRAIN, registered.
//   IDLE: if any m_cyc, grant first requester at or after ptr (round-robin). Go to OWN next cycle.
//    Grant latency is 1 clk. A requester sees m_stall=1 in the cycle it first raises cyc.
//   OWN: alu_cycle=1. alu_strobe = m_stb[g] & (outst!=limit). Op/operands muxed from g.
//    m_stall[g] = alu_stall | (outst==limit).
//    m_ack[g] = alu_ack, with m_pl/m_pr = alu_pl/alu_pr.
//    When m_cyc[g] falls: if outst==0 -> IDLE, else -> DRAIN.
//   DRAIN: alu_cycle=1, alu_strobe=0, all m_ack=0. Late acks decrement outst and are discarded.
//    Go to IDLE when outst==0 and no ack is arriving.
//   Leaving OWN/DRAIN: ptr=g+1 mod NM, m_gnt=0.
//    An IDLE cycle always separates two grants, so alu_top sees alu_cycle low for 1 clk.
//  Outstanding counter:
//   +1 on alu_strobe & !alu_stall; -1 on alu_ack; same cycle -> unchanged.
//   Ack with outst==0 is ignored (no underflow) and flagged in the sim-only assertion.
//  Function ops (op[8]=1): alu_top stalls until done, then acks in the same cycle. The counter sees +1 and -1 together, net 0.
//  Non-granted masters: m_ack=0, m_stall=1, regardless of their m_stb.
//  Simultaneous requests: lowest index at or after ptr wins.
//  Reset mid-transaction: immediate return to the reset values. An in-flight ALU result is lost; masters must re-issue.
//  No combinational path from m_cyc to alu_cycle: the grant comes from a register. Mux is pure combinational on g.
// STRUCTURE
//  globals.vh: `ALU_ARB_IDLE/OWN/DRAIN` state codes and `ALU_OP_FUNC_BIT` (=8).
//  Sub-module rr_arbiter_pick (req[NM], ptr) -> one-hot pick. Combinational, reused by the future memory arbiter.
//  Top level holds the FSM, the counter and the operand muxes.
// TESTING
//  1. Only m0: cyc+stb, op=DSP MUL, al=2, bl=3, one strobe.
//     -> m_gnt=0001 one clk later; m_ack[0] 3 clk after accepted strobe; m_pl=6.
//  2. m0 and m2 raise cyc in the same clk, ptr=0.
//     -> m0 granted; after m0 drops cyc, 1 IDLE clk, then m2 granted; ptr ends at 3.
//  3. m1: 5 back-to-back DSP strobes.
//     -> 4th strobe stalled (outst=3); all 5 acks delivered in order; outst returns to 0.
//  4. m3 issues SIN and holds stb.
//     -> m_stall[3]=1 until calc done, then ack and stall=0 in the same clk; outst stays 0.
//  5. m0 drops cyc with 2 DSP ops pending.
//     -> DRAIN; 2 acks swallowed (m_ack=0); IDLE after the last; m1 request waits until then.
//  6. Assert reset during OWN with outst=2.
//     -> next edge: m_gnt=0, alu_cycle=0, m_stall=all-ones, outst=0.

Source files
------------

// File: rtl/alu_wb_arbiter_pkg.sv
// Shared types and helpers for the ALU Wishbone arbiter and its round-robin picker.
// State encoding, datapath widths and the function-op flag bit of alu_op.
package alu_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    localparam int ALU_OP_FUNC_BIT = 8;
    localparam int OP_W   = 9;
    localparam int AB_W   = 18;
    localparam int C_W    = 48;
    localparam int P_W    = 48;
    localparam int NM_MAX = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [NM_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NM_MAX; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/alu_wb_arbiter_pick.sv
// Combinational round-robin picker: one-hot select of the first requester at or after ptr.
// Kept generic so the memory arbiter can reuse it.
module rr_arbiter_pick #(
    parameter int NM = 4,
    parameter int PW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NM-1:0] pick
);

    always_comb begin
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NM; i++) begin
            idx = (int'(ptr) + i) % NM;
            if (!found && req[PW'(idx)]) begin
                pick[PW'(idx)] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of alu_top: one registered grant per bus cycle,
// operand mux towards the ALU, ack/stall routing back and outstanding-request tracking.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ARB_IDLE  | no owner; alu_cycle low; picks next requester round-robin
//  ARB_OWN   | granted master drives the ALU; acks routed back to it
//  ARB_DRAIN | owner dropped cyc; late acks swallowed until outst is 0
module alu_wb_arbiter
    import alu_wb_arbiter_pkg::*;
#(
    parameter int NM    = 4,
    parameter int OUT_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NM-1:0]      m_cyc,
    input  logic [NM-1:0]      m_stb,
    input  logic [NM*OP_W-1:0] m_op,
    input  logic [NM*AB_W-1:0] m_al,
    input  logic [NM*AB_W-1:0] m_ar,
    input  logic [NM*AB_W-1:0] m_bl,
    input  logic [NM*AB_W-1:0] m_br,
    input  logic [NM*C_W-1:0]  m_cl,
    input  logic [NM*C_W-1:0]  m_cr,
    output logic [NM-1:0]      m_ack,
    output logic [NM-1:0]      m_stall,
    output logic [P_W-1:0]     m_pl,
    output logic [P_W-1:0]     m_pr,
    output logic [NM-1:0]      m_gnt,
    output logic               alu_cycle,
    output logic               alu_strobe,
    output logic [OP_W-1:0]    alu_op,
    output logic [AB_W-1:0]    alu_al,
    output logic [AB_W-1:0]    alu_bl,
    output logic [AB_W-1:0]    alu_ar,
    output logic [AB_W-1:0]    alu_br,
    output logic [C_W-1:0]     alu_cl,
    output logic [C_W-1:0]     alu_cr,
    input  logic               alu_ack,
    input  logic               alu_stall,
    input  logic [P_W-1:0]     alu_pl,
    input  logic [P_W-1:0]     alu_pr
);

    localparam int PW = $clog2(NM);
    localparam logic [OUT_W-1:0] OUT_LIMIT = '1;

    arb_state_t     state;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  g;
    logic [PW-1:0]  ptr_nxt;
    logic [OUT_W-1:0] outst;
    logic [NM-1:0]  pick;
    logic           own;
    logic           full;
    logic           g_cyc;
    logic           g_stb;
    logic           inc;
    logic           dec;

    rr_arbiter_pick #(.NM(NM), .PW(PW)) u_pick (
        .req  (m_cyc),
        .ptr  (ptr),
        .pick (pick)
    );

    always_comb begin
        g       = PW'(onehot_to_idx(NM_MAX'(m_gnt)));
        ptr_nxt = (g == PW'(NM - 1)) ? '0 : g + PW'(1);
        own     = (state == ARB_OWN);
        full    = (outst == OUT_LIMIT);
        g_cyc   = |(m_cyc & m_gnt);
        g_stb   = |(m_stb & m_gnt);
    end

    // ALU side: driven only by the registered grant, never directly by m_cyc.
    always_comb begin
        alu_cycle  = (state != ARB_IDLE);
        alu_strobe = own & g_cyc & g_stb & ~full;
        alu_op     = '0;
        alu_al     = '0;
        alu_bl     = '0;
        alu_ar     = '0;
        alu_br     = '0;
        alu_cl     = '0;
        alu_cr     = '0;
        if (own) begin
            for (int i = 0; i < NM; i++) begin
                if (m_gnt[i]) begin
                    alu_op = m_op[i*OP_W +: OP_W];
                    alu_al = m_al[i*AB_W +: AB_W];
                    alu_bl = m_bl[i*AB_W +: AB_W];
                    alu_ar = m_ar[i*AB_W +: AB_W];
                    alu_br = m_br[i*AB_W +: AB_W];
                    alu_cl = m_cl[i*C_W +: C_W];
                    alu_cr = m_cr[i*C_W +: C_W];
                end
            end
        end
    end

    always_comb begin
        m_stall = '1;
        m_ack   = '0;
        m_pl    = '0;
        m_pr    = '0;
        if (own) begin
            m_stall = ~m_gnt | (m_gnt & {NM{alu_stall | full}});
            m_ack   = m_gnt & {NM{alu_ack}};
            if (alu_ack) begin
                m_pl = alu_pl;
                m_pr = alu_pr;
            end
        end
    end

    // A function op is accepted and acked in the same cycle, so an ack with
    // outst==0 is legal only when paired with an accept.
    always_comb begin
        inc = alu_strobe & ~alu_stall;
        dec = alu_ack & ((outst != '0) | inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            m_gnt <= '0;
            ptr   <= '0;
            outst <= '0;
        end else begin
            if (inc && !dec) begin
                outst <= outst + OUT_W'(1);
            end else if (dec && !inc) begin
                outst <= outst - OUT_W'(1);
            end
            case (state)
                ARB_IDLE: begin
                    if (|m_cyc) begin
                        m_gnt <= pick;
                        state <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (!g_cyc) begin
                        if (outst == '0) begin
                            state <= ARB_IDLE;
                            m_gnt <= '0;
                            ptr   <= ptr_nxt;
                        end else begin
                            state <= ARB_DRAIN;
                        end
                    end
                end
                ARB_DRAIN: begin
                    if (outst == '0 && !alu_ack) begin
                        state <= ARB_IDLE;
                        m_gnt <= '0;
                        ptr   <= ptr_nxt;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    m_gnt <= '0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    ack_underflow_a: assert property (@(posedge clk) disable iff (reset)
        !(alu_ack && outst == '0 && !inc));
    func_same_cycle_ack_a: assert property (@(posedge clk) disable iff (reset)
        (inc && alu_op[ALU_OP_FUNC_BIT]) |-> alu_ack);
`endif

endmodule
